multicycle_controller: RTL and testbench

- Multi-cycle MIPS control FSM for the shared-memory, single-ALU datapath.
- Sequences one instruction over 3–5+ cycles: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- Reuses the instruction set and ALUOp encoding of the single-cycle decoder.
- Stalls on a memory ready handshake.

---
 rtl/multicycle_controller_pkg.sv | 83 ++++++++
 rtl/alu_op_decode.sv | 40 ++++
 rtl/multicycle_controller.sv | 153 +++++++++++++++
 tb/tb_multicycle_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: ALU ops, opcodes, functs,
// FSM states and datapath mux selects.
package multicycle_controller_pkg;

    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SEL_W    = 2;

    // Datapath constants, kept here for reference; the datapath owns the values.
    localparam int unsigned PC_INC = 4;
    localparam int unsigned RA_REG = 31;

    localparam logic [ALU_OP_W-1:0] op_nop = 4'd0;
    localparam logic [ALU_OP_W-1:0] op_add = 4'd1;
    localparam logic [ALU_OP_W-1:0] op_sub = 4'd2;
    localparam logic [ALU_OP_W-1:0] op_and = 4'd3;
    localparam logic [ALU_OP_W-1:0] op_or  = 4'd4;
    localparam logic [ALU_OP_W-1:0] op_xor = 4'd5;
    localparam logic [ALU_OP_W-1:0] op_nor = 4'd6;
    localparam logic [ALU_OP_W-1:0] op_slt = 4'd7;
    localparam logic [ALU_OP_W-1:0] op_sll = 4'd8;
    localparam logic [ALU_OP_W-1:0] op_srl = 4'd9;
    localparam logic [ALU_OP_W-1:0] op_beq = 4'd10;
    localparam logic [ALU_OP_W-1:0] op_bne = 4'd11;

    localparam logic [OPCODE_W-1:0] opc_rtype = 6'h00;
    localparam logic [OPCODE_W-1:0] opc_j     = 6'h02;
    localparam logic [OPCODE_W-1:0] opc_jal   = 6'h03;
    localparam logic [OPCODE_W-1:0] opc_beq   = 6'h04;
    localparam logic [OPCODE_W-1:0] opc_bne   = 6'h05;
    localparam logic [OPCODE_W-1:0] opc_addi  = 6'h08;
    localparam logic [OPCODE_W-1:0] opc_slti  = 6'h0A;
    localparam logic [OPCODE_W-1:0] opc_andi  = 6'h0C;
    localparam logic [OPCODE_W-1:0] opc_lw    = 6'h23;
    localparam logic [OPCODE_W-1:0] opc_sw    = 6'h2B;

    localparam logic [FUNCT_W-1:0] fn_sll = 6'h00;
    localparam logic [FUNCT_W-1:0] fn_srl = 6'h02;
    localparam logic [FUNCT_W-1:0] fn_jr  = 6'h08;
    localparam logic [FUNCT_W-1:0] fn_add = 6'h20;
    localparam logic [FUNCT_W-1:0] fn_sub = 6'h22;
    localparam logic [FUNCT_W-1:0] fn_and = 6'h24;
    localparam logic [FUNCT_W-1:0] fn_or  = 6'h25;
    localparam logic [FUNCT_W-1:0] fn_xor = 6'h26;
    localparam logic [FUNCT_W-1:0] fn_nor = 6'h27;
    localparam logic [FUNCT_W-1:0] fn_slt = 6'h2A;

    typedef enum logic [STATE_W-1:0] {
        st_fetch    = 4'd0,
        st_decode   = 4'd1,
        st_ex_r     = 4'd2,
        st_ex_i     = 4'd3,
        st_mem_addr = 4'd4,
        st_mem_rd   = 4'd5,
        st_mem_wb   = 4'd6,
        st_mem_wr   = 4'd7,
        st_wb_r     = 4'd8,
        st_wb_i     = 4'd9,
        st_branch   = 4'd10,
        st_jump     = 4'd11
    } state_e;

    localparam logic [SEL_W-1:0] pc_src_alu    = 2'd0;
    localparam logic [SEL_W-1:0] pc_src_target = 2'd1;
    localparam logic [SEL_W-1:0] pc_src_jump   = 2'd2;
    localparam logic [SEL_W-1:0] pc_src_rs     = 2'd3;

    localparam logic [SEL_W-1:0] srcb_rt      = 2'd0;
    localparam logic [SEL_W-1:0] srcb_inc     = 2'd1;
    localparam logic [SEL_W-1:0] srcb_imm     = 2'd2;
    localparam logic [SEL_W-1:0] srcb_imm_sl2 = 2'd3;

    localparam logic [SEL_W-1:0] dst_rt = 2'd0;
    localparam logic [SEL_W-1:0] dst_rd = 2'd1;
    localparam logic [SEL_W-1:0] dst_ra = 2'd2;

    localparam logic [SEL_W-1:0] m2r_alu = 2'd0;
    localparam logic [SEL_W-1:0] m2r_mdr = 2'd1;
    localparam logic [SEL_W-1:0] m2r_pc  = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: ALU operation and legality for the current IR.
module alu_op_decode
    import multicycle_controller_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALU_OP_W-1:0] alu_op_c,
    output logic                legal_c
);

    always_comb begin
        alu_op_c = op_nop;
        legal_c  = 1'b1;
        case (opcode)
            opc_rtype: begin
                case (funct)
                    fn_add:  alu_op_c = op_add;
                    fn_sub:  alu_op_c = op_sub;
                    fn_and:  alu_op_c = op_and;
                    fn_or:   alu_op_c = op_or;
                    fn_xor:  alu_op_c = op_xor;
                    fn_nor:  alu_op_c = op_nor;
                    fn_slt:  alu_op_c = op_slt;
                    fn_sll:  alu_op_c = op_sll;
                    fn_srl:  alu_op_c = op_srl;
                    fn_jr:   alu_op_c = op_nop;
                    default: legal_c  = 1'b0;
                endcase
            end
            opc_addi, opc_lw, opc_sw: alu_op_c = op_add;
            opc_andi:                 alu_op_c = op_and;
            opc_slti:                 alu_op_c = op_slt;
            opc_beq:                  alu_op_c = op_beq;
            opc_bne:                  alu_op_c = op_bne;
            opc_j, opc_jal:           alu_op_c = op_nop;
            default:                  legal_c  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM for a shared-memory, single-ALU datapath.
// Control outputs are decoded from the current state and are all zero while rst is high.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                branch_cond,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic [SEL_W-1:0]    pc_src,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_write,
    output logic [SEL_W-1:0]    reg_dst,
    output logic [SEL_W-1:0]    mem_to_reg,
    output logic                illegal_instr,
    output logic [STATE_W-1:0]  state
);

    state_e              state_q;
    state_e              state_d;
    logic [ALU_OP_W-1:0] dec_alu_op_c;
    logic                dec_legal_c;

    alu_op_decode u_alu_op_decode (
        .opcode   (opcode),
        .funct    (funct),
        .alu_op_c (dec_alu_op_c),
        .legal_c  (dec_legal_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= st_fetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            st_fetch: if (mem_ready) state_d = st_decode;
            st_decode: begin
                state_d = st_fetch;
                if (dec_legal_c) begin
                    case (opcode)
                        opc_rtype:                state_d = (funct == fn_jr) ? st_jump : st_ex_r;
                        opc_addi, opc_andi,
                        opc_slti:                 state_d = st_ex_i;
                        opc_lw, opc_sw:           state_d = st_mem_addr;
                        opc_beq, opc_bne:         state_d = st_branch;
                        opc_j, opc_jal:           state_d = st_jump;
                        default:                  state_d = st_fetch;
                    endcase
                end
            end
            st_ex_r:     state_d = st_wb_r;
            st_ex_i:     state_d = st_wb_i;
            st_mem_addr: state_d = (opcode == opc_lw) ? st_mem_rd : st_mem_wr;
            st_mem_rd:   if (mem_ready) state_d = st_mem_wb;
            st_mem_wr:   if (mem_ready) state_d = st_fetch;
            default:     state_d = st_fetch;
        endcase
    end

    // Output decode; rst masks everything so an abandoned instruction cannot write.
    always_comb begin
        pc_write      = 1'b0;
        pc_src        = pc_src_alu;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = srcb_rt;
        alu_op        = op_nop;
        reg_write     = 1'b0;
        reg_dst       = dst_rt;
        mem_to_reg    = m2r_alu;
        illegal_instr = 1'b0;
        if (!rst) begin
            case (state_q)
                st_fetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = srcb_inc;
                    alu_op    = op_add;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                st_decode: begin
                    alu_src_b     = srcb_imm_sl2;
                    alu_op        = op_add;
                    illegal_instr = !dec_legal_c;
                end
                st_ex_r: begin
                    alu_src_a = 1'b1;
                    alu_op    = dec_alu_op_c;
                end
                st_wb_r: begin
                    alu_op    = dec_alu_op_c;
                    reg_write = 1'b1;
                    reg_dst   = dst_rd;
                end
                st_ex_i, st_mem_addr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = srcb_imm;
                    alu_op    = dec_alu_op_c;
                end
                st_wb_i: reg_write = 1'b1;
                st_mem_rd: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                st_mem_wb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = m2r_mdr;
                end
                st_mem_wr: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                st_branch: begin
                    alu_src_a = 1'b1;
                    alu_op    = dec_alu_op_c;
                    pc_src    = pc_src_target;
                    pc_write  = branch_cond;
                end
                st_jump: begin
                    pc_write = 1'b1;
                    pc_src   = (opcode == opc_rtype) ? pc_src_rs : pc_src_jump;
                    if (opcode == opc_jal) begin
                        reg_write  = 1'b1;
                        reg_dst    = dst_ra;
                        mem_to_reg = m2r_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected controls are queued with their inputs.
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       illegal;
    } outs_t;

    typedef struct {
        string      name;
        logic       rdy;
        logic       bc;
        logic [5:0] op;
        logic [5:0] fn;
        outs_t      exp;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       branch_cond = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a;
    logic       reg_write, illegal_instr;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic [3:0] alu_op, state;

    cyc_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    multicycle_controller dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct         (funct),
        .branch_cond   (branch_cond),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .illegal_instr (illegal_instr),
        .state         (state)
    );

    always #5 clk = ~clk;

    function automatic outs_t mk(int st, int pcw, int pcs, int irw, int mr, int mw, int iod,
                                 int asa, int asb, int aop, int rw, int rd, int m2r, int ill);
        outs_t o;
        o.st = 4'(st);           o.pc_write = 1'(pcw);   o.pc_src = 2'(pcs);
        o.ir_write = 1'(irw);    o.mem_read = 1'(mr);    o.mem_write = 1'(mw);
        o.i_or_d = 1'(iod);      o.alu_src_a = 1'(asa);  o.alu_src_b = 2'(asb);
        o.alu_op = 4'(aop);      o.reg_write = 1'(rw);   o.reg_dst = 2'(rd);
        o.mem_to_reg = 2'(m2r);  o.illegal = 1'(ill);
        return o;
    endfunction

    function automatic outs_t observe();
        return {state, pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, alu_src_a,
                alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_instr};
    endfunction

    function automatic outs_t f_ok();   return mk(0, 1,0,1,1,0,0, 0,1,1, 0,0,0,0); endfunction
    function automatic outs_t f_wait(); return mk(0, 0,0,0,1,0,0, 0,1,1, 0,0,0,0); endfunction
    function automatic outs_t f_dec(int ill); return mk(1, 0,0,0,0,0,0, 0,3,1, 0,0,0,ill); endfunction

    task automatic push(string name, logic rdy, logic bc, logic [5:0] op, logic [5:0] fn, outs_t e);
        cyc_t c;
        c.name = name; c.rdy = rdy; c.bc = bc; c.op = op; c.fn = fn; c.exp = e;
        sb.push_back(c);
    endtask

    // Entered and left at posedge+1; each entry is one clock cycle.
    task automatic drain();
        cyc_t  c;
        outs_t act;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            mem_ready = c.rdy; branch_cond = c.bc; opcode = c.op; funct = c.fn;
            @(negedge clk);
            act = observe();
            tests_run++;
            if (act !== c.exp) begin
                tests_failed++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'h23;
        #2;
        tests_run++;
        if (observe() !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", observe());
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_r_type();
        logic [5:0] fns  [4] = '{6'h20, 6'h02, 6'h27, 6'h2A};
        int         aops [4] = '{1, 9, 6, 7};
        for (int i = 0; i < 4; i++) begin
            push("r_fetch", 1, 0, 6'h00, fns[i], f_ok());
            push("r_decode", 0, 0, 6'h00, fns[i], f_dec(0));
            push("r_ex", 0, 0, 6'h00, fns[i], mk(2, 0,0,0,0,0,0, 1,0,aops[i], 0,0,0,0));
            push("r_wb", 0, 0, 6'h00, fns[i], mk(8, 0,0,0,0,0,0, 0,0,aops[i], 1,1,0,0));
        end
        drain();
    endtask

    task automatic test_i_type();
        logic [5:0] ops  [3] = '{6'h08, 6'h0C, 6'h0A};
        int         aops [3] = '{1, 3, 7};
        for (int i = 0; i < 3; i++) begin
            push("i_fetch", 1, 0, ops[i], 6'h11, f_ok());
            push("i_decode", 0, 0, ops[i], 6'h11, f_dec(0));
            push("i_ex", 0, 0, ops[i], 6'h11, mk(3, 0,0,0,0,0,0, 1,2,aops[i], 0,0,0,0));
            push("i_wb", 0, 0, ops[i], 6'h11, mk(9, 0,0,0,0,0,0, 0,0,0, 1,0,0,0));
        end
        drain();
    endtask

    task automatic test_lw_stall();
        push("lw_fetch_wait", 0, 0, 6'h23, 6'h00, f_wait());
        push("lw_fetch", 1, 0, 6'h23, 6'h00, f_ok());
        push("lw_decode", 0, 0, 6'h23, 6'h00, f_dec(0));
        push("lw_addr", 0, 0, 6'h23, 6'h00, mk(4, 0,0,0,0,0,0, 1,2,1, 0,0,0,0));
        push("lw_rd_wait0", 0, 0, 6'h23, 6'h00, mk(5, 0,0,0,1,0,1, 0,0,0, 0,0,0,0));
        push("lw_rd_wait1", 0, 0, 6'h23, 6'h00, mk(5, 0,0,0,1,0,1, 0,0,0, 0,0,0,0));
        push("lw_rd_done", 1, 0, 6'h23, 6'h00, mk(5, 0,0,0,1,0,1, 0,0,0, 0,0,0,0));
        push("lw_wb", 1, 0, 6'h23, 6'h00, mk(6, 0,0,0,0,0,0, 0,0,0, 1,0,1,0));
        drain();
    endtask

    task automatic test_sw();
        push("sw_fetch", 1, 0, 6'h2B, 6'h00, f_ok());
        push("sw_decode", 0, 0, 6'h2B, 6'h00, f_dec(0));
        push("sw_addr", 0, 0, 6'h2B, 6'h00, mk(4, 0,0,0,0,0,0, 1,2,1, 0,0,0,0));
        push("sw_wr_wait", 0, 0, 6'h2B, 6'h00, mk(7, 0,0,0,0,1,1, 0,0,0, 0,0,0,0));
        push("sw_wr_done", 1, 0, 6'h2B, 6'h00, mk(7, 0,0,0,0,1,1, 0,0,0, 0,0,0,0));
        drain();
    endtask

    task automatic test_branch();
        push("beq_fetch", 1, 0, 6'h04, 6'h00, f_ok());
        push("beq_decode", 0, 0, 6'h04, 6'h00, f_dec(0));
        push("beq_taken", 0, 1, 6'h04, 6'h00, mk(10, 1,1,0,0,0,0, 1,0,10, 0,0,0,0));
        push("bne_fetch", 1, 0, 6'h05, 6'h00, f_ok());
        push("bne_decode", 0, 0, 6'h05, 6'h00, f_dec(0));
        push("bne_not_taken", 0, 0, 6'h05, 6'h00, mk(10, 0,1,0,0,0,0, 1,0,11, 0,0,0,0));
        drain();
    endtask

    task automatic test_jump();
        push("jal_fetch", 1, 0, 6'h03, 6'h00, f_ok());
        push("jal_decode", 0, 0, 6'h03, 6'h00, f_dec(0));
        push("jal_jump", 0, 0, 6'h03, 6'h00, mk(11, 1,2,0,0,0,0, 0,0,0, 1,2,2,0));
        push("j_fetch", 1, 0, 6'h02, 6'h00, f_ok());
        push("j_decode", 0, 0, 6'h02, 6'h00, f_dec(0));
        push("j_jump", 0, 0, 6'h02, 6'h00, mk(11, 1,2,0,0,0,0, 0,0,0, 0,0,0,0));
        push("jr_fetch", 1, 0, 6'h00, 6'h08, f_ok());
        push("jr_decode", 0, 0, 6'h00, 6'h08, f_dec(0));
        push("jr_jump", 0, 0, 6'h00, 6'h08, mk(11, 1,3,0,0,0,0, 0,0,0, 0,0,0,0));
        drain();
    endtask

    task automatic test_illegal();
        push("ill_op_fetch", 1, 0, 6'h3F, 6'h20, f_ok());
        push("ill_op_decode", 0, 0, 6'h3F, 6'h20, f_dec(1));
        push("ill_op_refetch", 0, 0, 6'h3F, 6'h20, f_wait());
        push("ill_fn_fetch", 1, 0, 6'h00, 6'h3F, f_ok());
        push("ill_fn_decode", 1, 0, 6'h00, 6'h3F, f_dec(1));
        push("ill_fn_refetch", 0, 0, 6'h00, 6'h3F, f_wait());
        drain();
    endtask

    task automatic test_reset_mid_mem_wr();
        push("rwr_fetch", 1, 0, 6'h2B, 6'h00, f_ok());
        push("rwr_decode", 0, 0, 6'h2B, 6'h00, f_dec(0));
        push("rwr_addr", 0, 0, 6'h2B, 6'h00, mk(4, 0,0,0,0,0,0, 1,2,1, 0,0,0,0));
        push("rwr_wr_wait", 0, 0, 6'h2B, 6'h00, mk(7, 0,0,0,0,1,1, 0,0,0, 0,0,0,0));
        drain();
        mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (observe() !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_wr_outputs: got %h expected 0", observe());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (observe() !== f_wait()) begin
            tests_failed++;
            $display("FAIL rst_mid_wr_release: got %h expected %h", observe(), f_wait());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_lw_stall();
        test_sw();
        test_branch();
        test_jump();
        test_illegal();
        test_reset_mid_mem_wr();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
